// File: rtl/apb_master.sv
// APB master bridge: takes one valid/ready command at a time and runs it as an APB
// SETUP/ACCESS transfer, returning read data or a timeout error on a one-cycle strobe.
module apb_master #(
   parameter int unsigned ADDWIDTH  = 8,
   parameter int unsigned DATAWIDTH = 32,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic                   PCLK,
   input  logic                   PRESETn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDWIDTH-1:0]    req_addr,
   input  logic [DATAWIDTH-1:0]   req_wdata,
   input  logic [DATAWIDTH/8-1:0] req_strb,
   output logic                   rsp_valid,
   output logic                   rsp_err,
   output logic [DATAWIDTH-1:0]   rsp_rdata,
   output logic                   PSEL,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [ADDWIDTH-1:0]    PADDR,
   output logic [DATAWIDTH-1:0]   PWDATA,
   output logic [DATAWIDTH/8-1:0] PSTRB,
   input  logic                   PREADY,
   input  logic [DATAWIDTH-1:0]   PRDATA
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e          state;
   logic [CntW-1:0] wait_cnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= StIdle;
         wait_cnt  <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
      end else begin
         // Response fields are strobes: zero unless set below this cycle.
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         unique case (state)
            StIdle: begin
               if (req_ready && req_valid) begin
                  PWRITE    <= req_write;
                  PADDR     <= req_addr;
                  PWDATA    <= req_write ? req_wdata : '0;
                  PSTRB     <= req_write ? req_strb : '0;
                  PSEL      <= 1'b1;
                  req_ready <= 1'b0;
                  state     <= StSetup;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            StSetup: begin
               PENABLE  <= 1'b1;
               wait_cnt <= '0;
               state    <= StAccess;
            end
            StAccess: begin
               if (PREADY) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  state     <= StIdle;
               end else if (wait_cnt == CntMax) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= StIdle;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               PSEL      <= 1'b0;
               PENABLE   <= 1'b0;
               req_ready <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: slave model with programmable wait states, and a
// response scoreboard checking error flag, read data and accept-to-response latency.
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        req_valid, req_ready, req_write;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic [3:0]  PSTRB;

   apb_master #(.ADDWIDTH(8), .DATAWIDTH(32), .TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave model: PREADY rises after wait_states low ACCESS cycles.
   logic [31:0] mem [256];
   int wait_states = 0;
   int acc_cnt = 0;
   initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   assign PREADY = PSEL && PENABLE && (acc_cnt >= wait_states);
   assign PRDATA = mem[PADDR];
   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE)
         for (int b = 0; b < 4; b++)
            if (PSTRB[b]) mem[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
   end

   // Scoreboard
   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;
   exp_t exp_q[$];
   int   acc_edge[$];
   int   acc_log[$];
   bit   acc_rsp[$];
   int   cyc = 0;

   always @(posedge PCLK) begin
      cyc <= cyc + 1;
      if (PRESETn && req_valid && req_ready) begin
         acc_edge.push_back(cyc);
         acc_log.push_back(cyc);
         acc_rsp.push_back(rsp_valid);
      end
   end

   always @(negedge PCLK) begin
      if (PRESETn && rsp_valid) begin
         chk("rsp_expected", 128'(exp_q.size() != 0), 128'(1));
         if (exp_q.size() != 0) begin
            exp_t e;
            int   a;
            e = exp_q.pop_front();
            a = (acc_edge.size() != 0) ? acc_edge.pop_front() : -100;
            chk("rsp_err", 128'(rsp_err), 128'(e.err));
            chk("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
            chk("rsp_latency", 128'(cyc - 1 - a), 128'(e.lat));
         end
      end
   end

   task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [31:0] exp_pwdata,
                          input logic [3:0] exp_pstrb);
      int n_acc;
      int n;
      n_acc = (waits >= 16) ? 16 : waits + 1;
      wait_states = waits;
      exp_q.push_back('{exp_err, exp_rdata, n_acc + 1});
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_strb  = strb;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge PCLK); #1;
         n++;
      end
      chk("req_ready_wait", 128'(req_ready), 128'(1));
      @(posedge PCLK); #1;
      req_valid = 1'b0;
      chk("setup_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB},
          {1'b1, 1'b0, wr, addr, exp_pwdata, exp_pstrb});
      for (int i = 0; i < n_acc; i++) begin
         @(posedge PCLK); #1;
         chk("access_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB},
             {1'b1, 1'b1, wr, addr, exp_pwdata, exp_pstrb});
      end
      @(posedge PCLK); #1;
      chk("idle_after", {PSEL, PENABLE, req_ready}, 3'b001);
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge PCLK);
      #1;
      chk("rsp_seen", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETn   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      #12;
      chk("in_reset", {req_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                       rsp_valid, rsp_err, rsp_rdata}, 128'(0));
      PRESETn = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
      chk("after_reset", {req_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                          rsp_valid, rsp_err, rsp_rdata}, {1'b1, 81'(0)});

      // Zero-wait write, then read it back with write-side inputs left dirty.
      do_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 32'hDEADBEEF, 4'hF);
      do_xfer(1'b0, 8'h10, 32'h12345678, 4'hF, 0, 1'b0, 32'hDEADBEEF, 32'h0, 4'h0);
      // Partial-strobe write updates bytes 0 and 2 only.
      do_xfer(1'b1, 8'h10, 32'h11223344, 4'h5, 0, 1'b0, 32'h0, 32'h11223344, 4'h5);
      do_xfer(1'b0, 8'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDE22BE44, 32'h0, 4'h0);
      // Zero-strobe write still goes out on the bus.
      do_xfer(1'b1, 8'h30, 32'hCAFEF00D, 4'h0, 0, 1'b0, 32'h0, 32'hCAFEF00D, 4'h0);
      // Wait states, timeout abort, and PREADY on the last allowed cycle.
      do_xfer(1'b0, 8'h10, 32'h0, 4'h0, 3, 1'b0, 32'hDE22BE44, 32'h0, 4'h0);
      do_xfer(1'b0, 8'h10, 32'h0, 4'h0, 1000, 1'b1, 32'h0, 32'h0, 4'h0);
      do_xfer(1'b0, 8'h10, 32'h0, 4'h0, 15, 1'b0, 32'hDE22BE44, 32'h0, 4'h0);

      // Reset in the middle of ACCESS: bus drops at once and no response follows.
      wait_states = 1000;
      req_write = 1'b0;
      req_addr  = 8'h20;
      req_valid = 1'b1;
      @(posedge PCLK); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
      PRESETn = 1'b0;
      #1;
      chk("reset_mid_access", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b0000);
      repeat (2) @(posedge PCLK);
      #1;
      acc_edge.delete();
      PRESETn = 1'b1;
      repeat (3) @(posedge PCLK);
      #1;
      chk("idle_after_reset", {req_ready, PSEL, PENABLE, rsp_valid}, 4'b1000);

      // Back-to-back reads with req_valid held high.
      wait_states = 0;
      acc_log.delete();
      acc_rsp.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 32'hDE22BE44, 2});
      req_write = 1'b0;
      req_addr  = 8'h10;
      req_valid = 1'b1;
      for (int i = 0; i < 40 && acc_log.size() < 4; i++) begin
         @(posedge PCLK); #1;
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 128'(acc_log.size()), 128'(4));
      for (int i = 1; i < 4 && i < acc_log.size(); i++) begin
         chk("b2b_spacing", 128'(acc_log[i] - acc_log[i-1]), 128'(3));
         chk("b2b_accept_on_rsp", 128'(acc_rsp[i]), 128'(1));
      end
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge PCLK);
      #1;
      chk("b2b_rsp_done", 128'(exp_q.size()), 128'(0));
      repeat (5) @(posedge PCLK);
      #1;
      chk("final_idle", {req_ready, PSEL, PENABLE}, 3'b100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
